// File: rtl/lock_pkg.sv
// Shared definitions for the lock event annunciator.
//   state_t       : annunciator FSM state encoding
//   ms_to_cycles  : converts a duration in ms to clock cycles
//   buzzer_level  : maps a logical "buzzer on" to the physical output level
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEEP = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int ms_to_cycles(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

    function automatic logic buzzer_level(input logic on, input logic active_low);
        return active_low ? ~on : on;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a previous-value register, per bit.
//   clk, rst : clock and asynchronous active-high reset
//   din      : asynchronous input levels
//   edges    : one-cycle pulse when the synchronised level changes
//   level    : synchronised level (direction of the change when edges is set)
module sync_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] edges,
    output logic [W-1:0] level
);

    logic [W-1:0] s1_reg;
    logic [W-1:0] s2_reg;
    logic [W-1:0] prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            prev_reg <= '0;
        end else begin
            s1_reg   <= din;
            s2_reg   <= s1_reg;
            prev_reg <= s2_reg;
        end
    end

    assign edges = s2_reg ^ prev_reg;
    assign level = s2_reg;

endmodule

// File: rtl/lock_event_annunciator.sv
// Buzzer annunciator for lock open/close events.
//   clk, rst   : clock and asynchronous active-high reset
//   pos_sel    : per-channel lock position (1 = open), asynchronous
//   mute       : silences the buzzer and discards all events while high
//   buzzer     : registered buzzer drive, polarity set by ACTIVE_LOW
//   busy       : high while a pattern (including its trailing gap) plays
//   event_ch   : channel being announced, valid while busy
//   event_open : 1 = open event, 0 = close event, valid while busy
//   overflow   : one-cycle pulse when a pending event is overwritten
module lock_event_annunciator
    import lock_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int N_CH        = 1,
    parameter int BEEP_MS     = 200,
    parameter int GAP_MS      = 100,
    parameter int OPEN_BEEPS  = 1,
    parameter int CLOSE_BEEPS = 2,
    parameter int ACTIVE_LOW  = 1,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] pos_sel,
    input  logic            mute,
    output logic            buzzer,
    output logic            busy,
    output logic [CH_W-1:0] event_ch,
    output logic            event_open,
    output logic            overflow
);

    localparam int BEEP_CYC = ms_to_cycles(CLK_FREQ, BEEP_MS);
    localparam int GAP_CYC  = ms_to_cycles(CLK_FREQ, GAP_MS);
    localparam int MAX_CYC  = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
    localparam int CNT_W    = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic             BUZ_ON    = buzzer_level(1'b1, ACTIVE_LOW != 0);
    localparam logic             BUZ_OFF   = buzzer_level(1'b0, ACTIVE_LOW != 0);

    // ---------------------------------------------------------------- input path
    logic [N_CH-1:0] edges;
    logic [N_CH-1:0] level;

    sync_edge_det #(.W(N_CH)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (pos_sel),
        .edges (edges),
        .level (level)
    );

    // Edges are ignored until the synchronisers have settled after reset,
    // so a lock already open at power-up does not announce itself.
    logic [1:0] arm_reg;
    logic       armed;

    assign armed = (arm_reg == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            arm_reg <= 2'd0;
        else if (!armed)
            arm_reg <= arm_reg + 2'd1;
    end

    // ---------------------------------------------------------------- pending store
    logic [N_CH-1:0] pend_flag_reg;
    logic [N_CH-1:0] pend_type_reg;
    logic [N_CH-1:0] ovf_bits;
    logic            overflow_reg;
    logic            grant;
    logic [CH_W-1:0] gnt_ch;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_pend
            logic take;
            logic clr;

            assign take = armed & edges[gi] & ~mute;
            assign clr  = grant & (gnt_ch == CH_W'(gi));
            // A new edge in the grant cycle re-arms the flag without an overflow:
            // the old event is already being served, nothing is lost.
            assign ovf_bits[gi] = take & pend_flag_reg[gi] & ~clr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pend_flag_reg[gi] <= 1'b0;
                    pend_type_reg[gi] <= 1'b0;
                end else if (mute) begin
                    pend_flag_reg[gi] <= 1'b0;
                end else if (take) begin
                    pend_flag_reg[gi] <= 1'b1;
                    pend_type_reg[gi] <= level[gi];
                end else if (clr) begin
                    pend_flag_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow_reg <= 1'b0;
        else
            overflow_reg <= |ovf_bits;
    end

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        gnt_ch = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend_flag_reg[i])
                gnt_ch = CH_W'(i);
        end
    end

    // ---------------------------------------------------------------- pattern FSM
    state_t          state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       beeps_reg, beeps_next;
    logic [CH_W-1:0]  event_ch_reg;
    logic             event_open_reg;
    logic             buzzer_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        beeps_next = beeps_reg;
        grant      = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (|pend_flag_reg) begin
                    grant      = 1'b1;
                    state_next = BEEP;
                    beeps_next = pend_type_reg[gnt_ch] ? 3'(OPEN_BEEPS) : 3'(CLOSE_BEEPS);
                end
            end
            BEEP: begin
                if (cnt_reg == BEEP_LAST) begin
                    state_next = GAP;
                    cnt_next   = '0;
                    beeps_next = beeps_reg - 3'd1;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = (beeps_reg != 3'd0) ? BEEP : IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        if (mute) begin
            state_next = IDLE;
            cnt_next   = '0;
            grant      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            beeps_reg      <= 3'd0;
            event_ch_reg   <= '0;
            event_open_reg <= 1'b0;
            buzzer_reg     <= BUZ_OFF;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            beeps_reg  <= beeps_next;
            // Decoding the next state keeps the buzzer registered without
            // adding a cycle of latency.
            buzzer_reg <= (state_next == BEEP) ? BUZ_ON : BUZ_OFF;
            if (grant) begin
                event_ch_reg   <= gnt_ch;
                event_open_reg <= pend_type_reg[gnt_ch];
            end
        end
    end

    assign buzzer     = buzzer_reg;
    assign busy       = (state_reg != IDLE);
    assign event_ch   = event_ch_reg;
    assign event_open = event_open_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_lock_event_annunciator.sv
module tb_lock_event_annunciator;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pos_sel;
    logic       mute;
    logic       buzzer;
    logic       busy;
    logic [0:0] event_ch;
    logic       event_open;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    lock_event_annunciator #(
        .CLK_FREQ    (10000),
        .N_CH        (2),
        .BEEP_MS     (2),
        .GAP_MS      (1),
        .OPEN_BEEPS  (1),
        .CLOSE_BEEPS (2),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pos_sel    (pos_sel),
        .mute       (mute),
        .buzzer     (buzzer),
        .busy       (busy),
        .event_ch   (event_ch),
        .event_open (event_open),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected active-low buzzer for cycle t of a pattern of n beeps
    // (20 cycles on, 10 cycles off per beep).
    function automatic logic exp_buz(input int t, input int n);
        if (t >= n * 30) return 1'b1;
        return ((t % 30) < 20) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic exp_busy(input int t, input int n);
        return (t < n * 30);
    endfunction

    task automatic test_reset();
        int bad;
        rst = 1'b1; pos_sel = 2'b01; mute = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (buzzer !== 1'b1 || busy !== 1'b0 || event_ch !== 1'b0 || event_open !== 1'b0 || overflow !== 1'b0)
            $display("FAIL reset_values got buz=%b busy=%b ch=%b open=%b ovf=%b want 1 0 0 0 0",
                     buzzer, busy, event_ch, event_open, overflow);
        else n_pass++;
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (buzzer !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL reset_no_event active_cycles got %0d want 0", bad);
        else n_pass++;
        $display("reset: pos_sel=01 held, 200 cycles observed");
    endtask

    task automatic test_open();
        rst = 1'b1; pos_sel = 2'b10;
        repeat (3) tick();
        rst = 1'b0;
        repeat (8) tick();
        pos_sel = 2'b11;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if (buzzer !== 1'b1 || busy !== 1'b0)
                $display("FAIL open_latency edge=%0d got buz=%b busy=%b want 1 0", k, buzzer, busy);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (event_ch !== 1'b0 || event_open !== 1'b1)
            $display("FAIL open_event got ch=%b open=%b want 0 1", event_ch, event_open);
        else n_pass++;
        for (int t = 0; t <= 30; t++) begin
            if (t > 0) tick();
            n_checks++;
            if (buzzer !== exp_buz(t, 1) || busy !== exp_busy(t, 1))
                $display("FAIL open_pattern t=%0d got buz=%b busy=%b want %b %b",
                         t, buzzer, busy, exp_buz(t, 1), exp_busy(t, 1));
            else n_pass++;
        end
        $display("open: ch0 0->1 pattern checked");
    endtask

    task automatic test_close();
        pos_sel = 2'b01;
        repeat (4) tick();
        n_checks++;
        if (event_ch !== 1'b1 || event_open !== 1'b0)
            $display("FAIL close_event got ch=%b open=%b want 1 0", event_ch, event_open);
        else n_pass++;
        for (int t = 0; t <= 60; t++) begin
            if (t > 0) tick();
            n_checks++;
            if (buzzer !== exp_buz(t, 2) || busy !== exp_busy(t, 2))
                $display("FAIL close_pattern t=%0d got buz=%b busy=%b want %b %b",
                         t, buzzer, busy, exp_buz(t, 2), exp_busy(t, 2));
            else n_pass++;
        end
        $display("close: ch1 1->0 pattern checked");
    endtask

    task automatic test_back_to_back();
        // Reposition both channels silently under mute.
        mute = 1'b1; pos_sel = 2'b10;
        repeat (6) tick();
        mute = 1'b0;
        repeat (3) tick();
        pos_sel = 2'b01;
        repeat (4) tick();
        n_checks++;
        if (event_ch !== 1'b0 || event_open !== 1'b1)
            $display("FAIL b2b_first_event got ch=%b open=%b want 0 1", event_ch, event_open);
        else n_pass++;
        for (int t = 0; t <= 30; t++) begin
            if (t > 0) tick();
            n_checks++;
            if (buzzer !== exp_buz(t, 1) || busy !== exp_busy(t, 1))
                $display("FAIL b2b_first t=%0d got buz=%b busy=%b want %b %b",
                         t, buzzer, busy, exp_buz(t, 1), exp_busy(t, 1));
            else n_pass++;
        end
        tick();
        n_checks++;
        if (event_ch !== 1'b1 || event_open !== 1'b0)
            $display("FAIL b2b_second_event got ch=%b open=%b want 1 0", event_ch, event_open);
        else n_pass++;
        for (int t = 0; t <= 60; t++) begin
            if (t > 0) tick();
            n_checks++;
            if (buzzer !== exp_buz(t, 2) || busy !== exp_busy(t, 2))
                $display("FAIL b2b_second t=%0d got buz=%b busy=%b want %b %b",
                         t, buzzer, busy, exp_buz(t, 2), exp_busy(t, 2));
            else n_pass++;
        end
        $display("back_to_back: ch0 open then ch1 close checked");
    endtask

    task automatic test_overflow();
        int ovf_cnt;
        int len;
        pos_sel = 2'b00;
        repeat (4) tick();
        ovf_cnt = 0;
        for (int t = 0; t <= 60; t++) begin
            if (t > 0) tick();
            if (overflow === 1'b1) ovf_cnt++;
            n_checks++;
            if (buzzer !== exp_buz(t, 2) || busy !== exp_busy(t, 2))
                $display("FAIL ovf_ch0_pattern t=%0d got buz=%b busy=%b want %b %b",
                         t, buzzer, busy, exp_buz(t, 2), exp_busy(t, 2));
            else n_pass++;
            if (t == 5) pos_sel = 2'b10;
            if (t == 7) pos_sel = 2'b00;
        end
        n_checks++;
        if (ovf_cnt !== 1) $display("FAIL ovf_pulses got %0d want 1", ovf_cnt);
        else n_pass++;
        tick();
        n_checks++;
        if (event_ch !== 1'b1 || event_open !== 1'b0 || busy !== 1'b1)
            $display("FAIL ovf_ch1_event got ch=%b open=%b busy=%b want 1 0 1", event_ch, event_open, busy);
        else n_pass++;
        len = 0;
        for (int k = 0; k < 200; k++) begin
            if (busy !== 1'b1) break;
            len++;
            tick();
        end
        n_checks++;
        if (len !== 60) $display("FAIL ovf_ch1_busy_len got %0d want 60", len);
        else n_pass++;
        $display("overflow: ch1 toggled during ch0 pattern, %0d pulse(s)", ovf_cnt);
    endtask

    task automatic test_mute();
        int bad;
        pos_sel = 2'b01;
        repeat (4) tick();
        repeat (10) tick();
        n_checks++;
        if (buzzer !== 1'b0) $display("FAIL mute_pre got buz=%b want 0", buzzer);
        else n_pass++;
        mute = 1'b1;
        tick();
        n_checks++;
        if (buzzer !== 1'b1 || busy !== 1'b0)
            $display("FAIL mute_effect got buz=%b busy=%b want 1 0", buzzer, busy);
        else n_pass++;
        pos_sel = 2'b00;
        repeat (3) tick();
        pos_sel = 2'b01;
        repeat (5) tick();
        mute = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (buzzer !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL mute_no_replay active_cycles got %0d want 0", bad);
        else n_pass++;
        pos_sel = 2'b00;
        repeat (4) tick();
        n_checks++;
        if (event_ch !== 1'b0 || event_open !== 1'b0)
            $display("FAIL mute_fresh_event got ch=%b open=%b want 0 0", event_ch, event_open);
        else n_pass++;
        for (int t = 0; t <= 60; t++) begin
            if (t > 0) tick();
            n_checks++;
            if (buzzer !== exp_buz(t, 2) || busy !== exp_busy(t, 2))
                $display("FAIL mute_fresh t=%0d got buz=%b busy=%b want %b %b",
                         t, buzzer, busy, exp_buz(t, 2), exp_busy(t, 2));
            else n_pass++;
        end
        $display("mute: pattern cut, muted toggles dropped, fresh event played");
    endtask

    task automatic test_reset_mid();
        int bad;
        pos_sel = 2'b01;
        repeat (4) tick();
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (buzzer !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_mid got buz=%b busy=%b want 1 0", buzzer, busy);
        else n_pass++;
        repeat (3) tick();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL reset_mid_rearm busy_cycles got %0d want 0", bad);
        else n_pass++;
        $display("reset_mid: async reset during beep checked");
    endtask

    initial begin
        rst = 1'b1; pos_sel = 2'b00; mute = 1'b0;
        test_reset();
        test_open();
        test_close();
        test_back_to_back();
        test_overflow();
        test_mute();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lock_event_annunciator.md
Name: lock_event_annunciator

Overview:
Parametrised buzzer annunciator for the lock/servo subsystem. It monitors N_CH lock-position signals, one per servo or lock. It detects open and close transitions and plays a distinct beep pattern per event type: OPEN_BEEPS beeps on open, CLOSE_BEEPS beeps on close. Events are queued per channel and served by fixed-priority arbitration. It sits beside the servo controllers and is driven by the same pos_sel signals that select servo position.

Parameters:
CLK_FREQ, 50000000, clock frequency in Hz
N_CH, 1, number of monitored lock channels (1..8)
BEEP_MS, 200, beep on-time in ms
GAP_MS, 100, silence between beeps and after the last beep of a pattern, in ms
OPEN_BEEPS, 1, beeps per open event (1..7)
CLOSE_BEEPS, 2, beeps per close event (1..7)
ACTIVE_LOW, 1, 1 = buzzer output active-low; 0 = active-high

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  reset, asynchronous, active-high
pos_sel  in  N_CH  lock position per channel, 1 = open, asynchronous to clk
mute  in  1  synchronous; 1 = silence output and discard all events
buzzer  out  1  buzzer drive, registered, polarity per ACTIVE_LOW
busy  out  1  1 while a pattern is playing, including its trailing gap
event_ch  out  max(1,$clog2(N_CH))  channel currently being announced, valid while busy
event_open  out  1  1 = current event is open, 0 = close; valid while busy
overflow  out  1  one-cycle pulse when a pending event is overwritten

Behaviour:
- Reset values: buzzer inactive (= ACTIVE_LOW), busy 0, event_ch 0, event_open 0, overflow 0, all pending flags 0, FSM IDLE. Synchronisers, prev registers and arm counter all reset to 0.
- Input path, per channel:
  - Two-flop synchroniser s1 -> s2, then prev <= s2.
  - edge = s2 ^ prev; direction = s2.
- Arming: a 2-bit arm counter counts up after reset release and saturates at 3. Edges are ignored until it saturates, so a steady pos_sel=1 at reset produces no event.
- Pending store, per channel: flag plus type bit.
  - An edge sets the flag and writes the type.
  - If the flag is already set, the type is overwritten with the newest direction and overflow pulses.
- Arbitration: in IDLE with any flag set, pick the lowest-index pending channel. Its flag clears in the same cycle the FSM leaves IDLE.
- An edge on a channel in the cycle its flag is being cleared wins: the flag stays set with the new type, and there is no overflow pulse.
- FSM states: IDLE, BEEP, GAP.
  - IDLE -> BEEP on a grant. Load beeps_left = OPEN_BEEPS or CLOSE_BEEPS. Latch event_ch and event_open. busy = 1.
  - BEEP: buzzer active for BEEP_CYC = CLK_FREQ/1000*BEEP_MS cycles, then -> GAP and decrement beeps_left.
  - GAP: buzzer inactive for GAP_CYC = CLK_FREQ/1000*GAP_MS cycles. Then go to BEEP if beeps_left != 0, else to IDLE with busy = 0.
- Latency: the buzzer goes active on the 4th rising edge, counting the edge that first samples the new pos_sel level in s1. An idle FSM and armed block are required.
- Event with a free FSM: the next pattern starts the cycle after the FSM returns to IDLE. This gives one IDLE cycle between patterns.
- Duration counter: width $clog2(max(BEEP_CYC,GAP_CYC)+1). It resets to 0 on every state entry.
- mute = 1, effective next edge:
  - FSM forced to IDLE, buzzer inactive, busy 0.
  - All pending flags cleared; edges during mute are not stored.
  - Input synchronisers keep running.
- mute falling: no replay of events suppressed during mute.
- Asynchronous reset mid-pattern: buzzer returns inactive immediately and the arm sequence restarts.

Decomposition:
- Package lock_pkg holds:
  - FSM state encoding (IDLE = 2'd0, BEEP = 2'd1, GAP = 2'd2);
  - a function computing cycles from ms and CLK_FREQ;
  - the buzzer polarity helper.
- Sub-module sync_edge_det: two-flop synchroniser, prev register and edge/direction outputs. It has one parameterised width and is instantiated once with width N_CH.

Test Plan:
All scenarios use CLK_FREQ=10000 (10 cycles/ms), BEEP_MS=2 (20 cycles), GAP_MS=1 (10 cycles), N_CH=2, ACTIVE_LOW=1.
1. Reset with pos_sel=2'b01 held -> buzzer stays 1 and busy stays 0 for 200 cycles, with no event.
2. pos_sel[0] 0->1 -> buzzer 0 on the 4th edge, held 20 cycles, then 1. busy high for 30 cycles, event_ch=0, event_open=1.
3. pos_sel[1] 1->0 -> two low pulses of 20 cycles separated by 10 high. busy spans 60 cycles, event_ch=1, event_open=0.
4. Both channels change in the same cycle (ch0 open, ch1 close) -> ch0 pattern (1 beep), then after 1 IDLE cycle the ch1 pattern (2 beeps).
5. During the ch0 pattern, ch1 toggles 0->1->0 within 5 cycles -> one overflow pulse. The ch1 pattern that follows is close (2 beeps).
6. mute=1 at cycle 10 of a beep -> buzzer 1 and busy 0 next edge. Toggle ch0 while muted, release mute -> no pattern plays. A fresh toggle after release plays normally.
